pixel_writer: RTL
=================

PIXEL_WRITER -- requirements
Module: pixel_writer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port pixel_valid, input, 1 bit: one-cycle strobe, pixel present on x_in/y_in/color.
REQ-004 SHALL have ports x_in, y_in, inputs, 8 bits each: pixel coordinates.
REQ-005 SHALL have port color, input, 2 bits: pixel colour, sampled with pixel_valid.
REQ-006 SHALL have port tx_data, output, 8 bits: serial byte to display link.
REQ-007 SHALL have port tx_valid, output, 1 bit: tx_data holds a valid byte.
REQ-008 SHALL have port tx_ready, input, 1 bit: link accepts byte when tx_valid and tx_ready are both high.
REQ-009 SHALL have port fifo_full, output, 1 bit: pixel FIFO holds DEPTH entries.
REQ-010 SHALL have port idle, output, 1 bit: FIFO empty and no frame in flight.
REQ-011 SHALL have port overflow, output, 1 bit: sticky, a pixel was dropped.
REQ-012 SHALL have port clr_overflow, input, 1 bit: synchronous clear of overflow.
REQ-013 SHALL have parameter DEPTH, default 4, power of two >= 2: FIFO entries.
REQ-014 SHALL have parameter CMD_BASE, default 8'hA0: command byte upper bits.

Function
REQ-015 SHALL push {color, x_in, y_in} (18 bits) into the FIFO on every cycle pixel_valid=1, unless the FIFO is full.
REQ-016 SHALL, on push while full with no pop in the same cycle, drop the pixel, leave FIFO contents unchanged, and set overflow.
REQ-017 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; overflow stays unchanged.
REQ-018 SHALL serialise each pixel as exactly 3 bytes, in order: CMD_BASE | {6'b0, color}, then x, then y.
REQ-019 SHALL use FSM states IDLE, CMD, XB, YB.
REQ-020 IDLE: when FIFO not empty, SHALL pop the head into a frame register and go to CMD.
REQ-021 CMD/XB/YB: tx_valid=1 with the corresponding byte; on tx_ready, CMD->XB, XB->YB.
REQ-022 YB on tx_ready: SHALL pop the next entry and go to CMD if the FIFO is non-empty (no gap cycle), else go to IDLE.
REQ-023 SHALL hold tx_data and tx_valid stable while tx_valid=1 and tx_ready=0.
REQ-024 tx_valid SHALL be registered; with an empty FIFO and tx_ready=1, a pixel strobed in cycle N SHALL appear as tx_valid in cycle N+2.
REQ-025 SHALL sustain 1 byte/cycle under continuous tx_ready.
REQ-026 SHALL preserve FIFO order; pointers SHALL wrap modulo DEPTH, with an extra bit distinguishing full from empty.
REQ-027 clr_overflow SHALL take priority over a same-cycle overflow set.
REQ-028 idle SHALL equal (state==IDLE && FIFO empty), registered or combinational from registers only.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, FIFO empty, tx_valid=0, tx_data=0, overflow=0, fifo_full=0, idle=1.
REQ-030 Reset mid-frame SHALL abandon the frame and discard FIFO contents; after release, no partial frame is resumed.

Structure
REQ-031 The shared package SHALL hold the FSM state encoding and the CMD_BASE default; DEPTH stays a module parameter.
REQ-032 The FIFO SHALL be one sub-module, pixel_fifo (parameterised width/depth, push/pop/full/empty); pixel_writer instantiates it once.

Verification
REQ-033 Single pixel (x=5, y=9, color=2), tx_ready=1 -> bytes A2, 05, 09 on consecutive cycles starting at N+2; then idle=1.
REQ-034 Burst of 4 pixels on consecutive cycles, tx_ready=1 -> 12 bytes with no gap, overflow=0.
REQ-035 tx_ready low for 5 cycles during XB -> tx_data stays at x, tx_valid stays 1; sequence resumes correctly.
REQ-036 tx_ready=0 and 6 pixels pushed -> first pixel sits in the frame register, 4 in the FIFO, 6th dropped, overflow=1; clr_overflow -> 0.
REQ-037 Full FIFO plus simultaneous pop and push -> pixel accepted, overflow stays 0, order preserved.
REQ-038 rst_n asserted mid-YB -> tx_valid=0 at once; after release, idle=1 and no bytes are emitted.

Source files
------------

// File: rtl/pixel_writer_pkg.sv
// rtl/pixel_writer_pkg.sv - shared FSM encoding, frame layout and command-byte helper
package pixel_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    XB   = 2'd2,
    YB   = 2'd3
  } state_t;

  localparam logic [7:0] CMD_BASE_DEFAULT = 8'hA0;

  // FIFO entry layout: {color[1:0], x[7:0], y[7:0]}
  localparam int PIX_W = 18;

  function automatic logic [7:0] cmd_byte(input logic [7:0] base, input logic [1:0] color);
    return base | {6'b0, color};
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - synchronous FIFO with extra-bit pointers and show-ahead read
module pixel_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is still taken when a pop frees a slot in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update; the top bit separates full from empty when the indices match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pixel_writer.sv
// rtl/pixel_writer.sv - buffers pixels and serialises each as cmd/x/y bytes on the link
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] CMD_BASE = CMD_BASE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pixel_valid,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic [1:0] color,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       fifo_full,
  output logic       idle,
  output logic       overflow,
  input  logic       clr_overflow
);

  state_t           state;
  logic [PIX_W-1:0] frame;
  logic [PIX_W-1:0] head;
  logic             full;
  logic             empty;
  logic             pop_req;

  // Pop when starting a frame from IDLE, or back-to-back when the last byte is accepted
  assign pop_req = !empty && ((state == IDLE) || ((state == YB) && tx_ready));

  assign fifo_full = full;
  assign idle      = (state == IDLE) && empty;

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (pixel_valid),
    .pop   (pop_req),
    .wdata ({color, x_in, y_in}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // Frame FSM: registered tx_valid/tx_data, held while the link stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame    <= '0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            frame    <= head;
            tx_data  <= cmd_byte(CMD_BASE, head[17:16]);
            tx_valid <= 1'b1;
            state    <= CMD;
          end
        end
        CMD: begin
          if (tx_ready) begin
            tx_data <= frame[15:8];
            state   <= XB;
          end
        end
        XB: begin
          if (tx_ready) begin
            tx_data <= frame[7:0];
            state   <= YB;
          end
        end
        YB: begin
          if (tx_ready) begin
            if (!empty) begin
              frame    <= head;
              tx_data  <= cmd_byte(CMD_BASE, head[17:16]);
              tx_valid <= 1'b1;
              state    <= CMD;
            end else begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              state    <= IDLE;
            end
          end
        end
        default: begin
          tx_valid <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Sticky drop flag; a clear wins over a drop in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end else if (pixel_valid && full && !pop_req) begin
      overflow <= 1'b1;
    end
  end

endmodule
